surfturf_wb_arbiter: RTL

Round-robin Wishbone arbiter that shares the 12-bit-address / 32-bit-data control bus of the SURF/TURF link wrapper between several masters (e.g. host serial bridge, autonomous link-training sequencer, housekeeping). Grants whole bus cycles (held while the owner holds CYC), muxes the owner onto the single target port, and routes ACK/ERR/data back. A watchdog terminates cycles the target never acknowledges, because the wrapper hard-ties its ERR and RTY low.

---
 rtl/surfturf_wb_arbiter.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/surfturf_wb_arbiter.sv
`timescale 1ns/1ps
// surfturf_wb_arbiter
// Round-robin Wishbone arbiter sharing the SURF/TURF link-wrapper control bus
// between several masters. A grant covers a whole bus cycle (held while the
// owner keeps CYC high) and is never preempted. The owner's signals are muxed
// onto the single target port, and ACK/ERR are routed back to the owner only.
// Optional watchdog (define SURFTURF_ARB_TIMEOUT_EN): aborts strobes the target
// never answers, since the wrapper ties its ERR/RTY low.
module surfturf_wb_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                                 wb_clk_i,
  input  logic                                 wb_rst_i,
  input  logic [NUM_MASTERS-1:0]               m_cyc_i,
  input  logic [NUM_MASTERS-1:0]               m_stb_i,
  input  logic [NUM_MASTERS-1:0]               m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]    m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_dat_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]  m_sel_i,
  output logic [NUM_MASTERS-1:0]               m_ack_o,
  output logic [NUM_MASTERS-1:0]               m_err_o,
  output logic [DATA_WIDTH-1:0]                m_dat_o,
  output logic                                 s_cyc_o,
  output logic                                 s_stb_o,
  output logic                                 s_we_o,
  output logic [ADDR_WIDTH-1:0]                s_adr_o,
  output logic [DATA_WIDTH-1:0]                s_dat_o,
  output logic [DATA_WIDTH/8-1:0]              s_sel_o,
  input  logic                                 s_ack_i,
  input  logic                                 s_err_i,
  input  logic [DATA_WIDTH-1:0]                s_dat_i,
  output logic [NUM_MASTERS-1:0]               grant_o,
  output logic [15:0]                          timeout_cnt_o
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_WIDTH = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [IDX_WIDTH-1:0]   LAST_IDX = IDX_WIDTH'(NUM_MASTERS - 1);
  localparam logic [NUM_MASTERS-1:0] ONE_HOT0 = NUM_MASTERS'(1);

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  state_t                 state;
  logic [NUM_MASTERS-1:0] grant;
  logic [IDX_WIDTH-1:0]   owner;
  logic [IDX_WIDTH-1:0]   ptr;

  logic                   pick_valid;
  logic [IDX_WIDTH-1:0]   pick_idx;

  logic                   owned;
  logic                   owner_cyc;
  logic                   owner_stb;
  logic                   owner_we;
  logic [ADDR_WIDTH-1:0]  owner_adr;
  logic [DATA_WIDTH-1:0]  owner_dat;
  logic [SEL_WIDTH-1:0]   owner_sel;

  logic                   abort;
  logic                   abort_pulse;
  logic                   stb_out;

  // Round-robin search: first requester at or after ptr, wrapping around
  always_comb begin
    int cand;
    logic [IDX_WIDTH-1:0] cand_idx;
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_MASTERS) begin
        cand = cand - NUM_MASTERS;
      end
      cand_idx = IDX_WIDTH'(cand);
      if (!pick_valid && m_cyc_i[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Select the current owner's request fields from the packed master buses
  always_comb begin
    owner_cyc = 1'b0;
    owner_stb = 1'b0;
    owner_we  = 1'b0;
    owner_adr = '0;
    owner_dat = '0;
    owner_sel = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (owner == IDX_WIDTH'(i)) begin
        owner_cyc = m_cyc_i[i];
        owner_stb = m_stb_i[i];
        owner_we  = m_we_i[i];
        owner_adr = m_adr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        owner_dat = m_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
        owner_sel = m_sel_i[i*SEL_WIDTH +: SEL_WIDTH];
      end
    end
  end

  // Ownership FSM: grant a whole cycle from IDLE, return to IDLE when the owner drops CYC
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      grant <= '0;
      owner <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state <= OWNED;
            grant <= ONE_HOT0 << pick_idx;
            owner <= pick_idx;
          end
        end
        OWNED: begin
          if (!owner_cyc) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= (owner == LAST_IDX) ? '0 : owner + IDX_WIDTH'(1);
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  // Grant is the single source of truth for ownership, so reset drops every output at once
  assign owned   = |grant;
  assign grant_o = grant;

  assign stb_out = owned & owner_stb & ~abort;

  assign s_cyc_o = owned & owner_cyc;
  assign s_stb_o = stb_out;
  assign s_we_o  = owned & owner_we;
  assign s_adr_o = owned ? owner_adr : '0;
  assign s_dat_o = owned ? owner_dat : '0;
  assign s_sel_o = owned ? owner_sel : '0;

  // An ACK that arrives after the watchdog gave up belongs to a cycle the owner already saw fail
  assign m_ack_o = grant & {NUM_MASTERS{s_ack_i & ~abort}};
  assign m_err_o = grant & {NUM_MASTERS{s_err_i | abort_pulse}};
  assign m_dat_o = s_dat_i;

`ifdef SURFTURF_ARB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT);

  logic [15:0] wd_cnt;
  logic [15:0] timeout_cnt;

  assign abort_pulse   = stb_out & ~s_ack_i & ~s_err_i & (wd_cnt == TIMEOUT_VAL);
  assign timeout_cnt_o = timeout_cnt;

  // Watchdog: count unanswered strobe cycles, abort the owner's strobe on expiry
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wd_cnt      <= '0;
      abort       <= 1'b0;
      timeout_cnt <= '0;
    end else begin
      if (!stb_out || s_ack_i || s_err_i || abort_pulse) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 16'd1;
      end

      if (abort_pulse) begin
        abort <= 1'b1;
      end else if (!owned || !owner_stb || !owner_cyc) begin
        abort <= 1'b0;
      end

      if (abort_pulse && (timeout_cnt != 16'hFFFF)) begin
        timeout_cnt <= timeout_cnt + 16'd1;
      end
    end
  end
`else
  assign abort         = 1'b0;
  assign abort_pulse   = 1'b0;
  assign timeout_cnt_o = '0;
`endif

endmodule
